coppermem_arb: RTL and testbench
================================

# coppermem_arb

Access arbiter for the copper program memory (even and odd 16-bit `coppermem` banks). It shares the banks' read and write ports between two requesters:
- the copper engine, which makes 32-bit instruction fetches and 16-bit self-writes;
- the host register interface, which makes one-deep 16-bit reads and writes.

It sits between `copper`, the host register decode, and the two bank instances, in the single video clock domain.

## Interface
- `AWIDTH`, 10: bank address width; copper memory holds 2**(AWIDTH+1) words.
- `HOST_MAX_WAIT`, 4: max consecutive copper read grants while a host read is pending.

Clocking and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: sole clock.
- `reset_i` in 1: synchronous, active-high reset.

Copper fetch and write:
- `cop_rd_req_i` in 1: fetch request, level, held until acked.
- `cop_rd_addr_i` in AWIDTH: word-pair index.
- `cop_rd_ack_o` out 1: fetch granted this cycle.
- `cop_rd_valid_o` out 1: fetch data valid.
- `cop_rd_data_o` out 32: {even word, odd word}.
- `cop_wr_req_i` in 1: self-write request, level, held until acked.
- `cop_wr_addr_i` in AWIDTH+1: word address; bit 0 selects the bank (0 = even).
- `cop_wr_data_i` in 16: write data.
- `cop_wr_ack_o` out 1: write granted this cycle.

Host access:
- `host_rd_req_i` in 1: one-cycle read strobe.
- `host_rd_addr_i` in AWIDTH+1: word address.
- `host_rd_valid_o` out 1: one-cycle read-data strobe.
- `host_rd_data_o` out 16: read data.
- `host_wr_req_i` in 1: one-cycle write strobe.
- `host_wr_addr_i` in AWIDTH+1: word address.
- `host_wr_data_i` in 16: write data.
- `host_busy_o` out 1: a host read or write is pending.

Bank interface:
- `even_rd_en_o`, `odd_rd_en_o` out 1: per-bank read enable.
- `mem_rd_addr_o` out AWIDTH: shared bank read address.
- `even_rd_data_i`, `odd_rd_data_i` in 16: bank read data, 1-cycle registered.
- `even_wr_en_o`, `odd_wr_en_o` out 1: per-bank write enable.
- `mem_wr_addr_o` out AWIDTH: bank write address.
- `mem_wr_data_o` out 16: write data.

## Operation
Host pending registers:
- One pending register each for host reads (address) and host writes (address and data).
- A strobe loads its register on the next edge.
- A strobe arriving while that register is already pending is dropped. Software polls `host_busy_o`.
- `host_busy_o` = rd_pending | wr_pending (registered).

Read arbitration (evaluated combinationally each cycle):
- If rd_pending and (!cop_rd_req_i or starve_cnt == HOST_MAX_WAIT), grant the host:
  - assert only the selected bank's rd_en;
  - `mem_rd_addr_o` = host addr[AWIDTH:1];
  - clear rd_pending;
  - clear starve_cnt.
- Else, if cop_rd_req_i, grant the copper:
  - assert both rd_en;
  - `mem_rd_addr_o` = cop addr;
  - assert `cop_rd_ack_o`;
  - if rd_pending, starve_cnt increments, saturating at HOST_MAX_WAIT.
- Else the read enables are 0 and `mem_rd_addr_o` holds its last value.

Write arbitration (independent of reads):
- wr_pending has priority over the copper. On a host write grant, assert the selected bank's wr_en and clear wr_pending.
- Otherwise, cop_wr_req_i is granted: assert wr_en and `cop_wr_ack_o` in the same cycle.
- The copper write therefore stalls at most 1 cycle per host write.

Read-during-write:
- A read and a write to the same address in the same cycle returns the old data (BRAM read-first).
- No forwarding.

Return path:
- Registered grant tag: host or cop, plus the host bank bit.
- `cop_rd_data_o` = {even_rd_data_i, odd_rd_data_i}.
- `host_rd_data_o` = even or odd data selected by the registered bank bit.
- Both data outputs are passthrough of the bank outputs. Their values are defined only while the matching valid is high.

## Timing
- Reset values: all `_o` outputs are 0, rd_pending and wr_pending are 0, starve_cnt is 0, and the grant tag is idle.
- Copper fetch: ack in the grant cycle N; `cop_rd_valid_o` high for 1 cycle at N+1. Back-to-back fetches sustain 1 per cycle.
- Host read: strobe at T, pending at T+1, grant at T+1 at the earliest, valid at T+2. The worst case under a continuous copper fetch is a grant at T+1+HOST_MAX_WAIT.
- Host write: strobe at T, bank write enable at T+1, data readable by a read granted at T+2.
- Copper write: ack and wr_en in the same cycle when no host write is pending.
- Simultaneous host strobe and grant of an existing pending read: the old request is granted, the new strobe is dropped, and busy stays high for the old request only.
- Reset mid-operation:
  - pending requests are discarded;
  - an in-flight read's valid is suppressed;
  - no wr_en is asserted in the reset cycle.
- Address wrap: host addresses are the full AWIDTH+1 bits with no bounds check. The index wraps naturally.

## Test plan
- Idle host read: write 0x1234 to host addr 5, wait, then read addr 5 -> even? no, odd bank wr_en at T+1; read valid at T+2 after its strobe, with `host_rd_data_o` = 0x1234; `host_busy_o` falls after the grant.
- Copper fetch stream: fetch indices 0..7 every cycle with even/odd preloaded as i, i+0x100 -> 8 consecutive acks, valid one cycle later each, data {i, i+0x100}.
- Starvation bound: continuous copper fetch plus one host read, HOST_MAX_WAIT=4 -> exactly 4 copper acks, then the host grant (cop_rd_ack_o low for that cycle), host valid next cycle, and copper resumes.
- Write contention: host write and copper write pending together -> host wr_en first cycle, cop_wr_ack_o next cycle, both values read back correctly.
- Dropped strobe: host_rd_req_i twice while busy -> only the first read returns, exactly one host_rd_valid_o pulse.
- Reset mid-read: assert reset_i in the cycle after a host read grant -> host_rd_valid_o stays 0, busy 0, and the next request behaves as from idle.

Source files
------------

// File: rtl/coppermem_arb.sv
// Access arbiter sharing the even/odd copper program memory banks between the
// copper engine (32-bit fetches, 16-bit self-writes) and the host register port.
module coppermem_arb #(
  parameter int AWIDTH        = 10,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset_i,
  // copper fetch and self-write
  input  logic              cop_rd_req_i,
  input  logic [AWIDTH-1:0] cop_rd_addr_i,
  output logic              cop_rd_ack_o,
  output logic              cop_rd_valid_o,
  output logic [31:0]       cop_rd_data_o,
  input  logic              cop_wr_req_i,
  input  logic [AWIDTH:0]   cop_wr_addr_i,
  input  logic [15:0]       cop_wr_data_i,
  output logic              cop_wr_ack_o,
  // host register interface
  input  logic              host_rd_req_i,
  input  logic [AWIDTH:0]   host_rd_addr_i,
  output logic              host_rd_valid_o,
  output logic [15:0]       host_rd_data_o,
  input  logic              host_wr_req_i,
  input  logic [AWIDTH:0]   host_wr_addr_i,
  input  logic [15:0]       host_wr_data_i,
  output logic              host_busy_o,
  // bank ports
  output logic              even_rd_en_o,
  output logic              odd_rd_en_o,
  output logic [AWIDTH-1:0] mem_rd_addr_o,
  input  logic [15:0]       even_rd_data_i,
  input  logic [15:0]       odd_rd_data_i,
  output logic              even_wr_en_o,
  output logic              odd_wr_en_o,
  output logic [AWIDTH-1:0] mem_wr_addr_o,
  output logic [15:0]       mem_wr_data_o
);

  localparam int SW = (HOST_MAX_WAIT < 1) ? 1 : $clog2(HOST_MAX_WAIT + 1);
  localparam logic [SW-1:0] MAX_WAIT = SW'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {TAG_IDLE, TAG_COP, TAG_HOST} tag_e;

  logic              rd_pending, wr_pending;
  logic [AWIDTH:0]   rd_addr_q, wr_addr_q;
  logic [15:0]       wr_data_q;
  logic [SW-1:0]     starve_cnt;
  tag_e              tag_q;
  logic              host_bank_q;
  logic [AWIDTH-1:0] last_rd_addr_q;

  logic              host_rd_gnt, cop_rd_gnt, host_wr_gnt, cop_wr_gnt;
  logic [AWIDTH-1:0] rd_addr_nxt;

  // Every grant is masked during reset so no bank access starts in that cycle.
  always_comb begin
    host_rd_gnt = !reset_i && rd_pending && (!cop_rd_req_i || starve_cnt == MAX_WAIT);
    cop_rd_gnt  = !reset_i && !host_rd_gnt && cop_rd_req_i;
    host_wr_gnt = !reset_i && wr_pending;
    cop_wr_gnt  = !reset_i && !wr_pending && cop_wr_req_i;
  end

  always_comb begin
    rd_addr_nxt = last_rd_addr_q;
    if (host_rd_gnt)
      rd_addr_nxt = rd_addr_q[AWIDTH:1];
    else if (cop_rd_gnt)
      rd_addr_nxt = cop_rd_addr_i;
  end

  always_comb begin
    even_rd_en_o  = cop_rd_gnt || (host_rd_gnt && !rd_addr_q[0]);
    odd_rd_en_o   = cop_rd_gnt || (host_rd_gnt &&  rd_addr_q[0]);
    mem_rd_addr_o = reset_i ? '0 : rd_addr_nxt;
    cop_rd_ack_o  = cop_rd_gnt;

    even_wr_en_o  = 1'b0;
    odd_wr_en_o   = 1'b0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;
    cop_wr_ack_o  = cop_wr_gnt;
    if (host_wr_gnt) begin
      even_wr_en_o  = !wr_addr_q[0];
      odd_wr_en_o   =  wr_addr_q[0];
      mem_wr_addr_o = wr_addr_q[AWIDTH:1];
      mem_wr_data_o = wr_data_q;
    end else if (cop_wr_gnt) begin
      even_wr_en_o  = !cop_wr_addr_i[0];
      odd_wr_en_o   =  cop_wr_addr_i[0];
      mem_wr_addr_o = cop_wr_addr_i[AWIDTH:1];
      mem_wr_data_o = cop_wr_data_i;
    end
  end

  // Return path: valids are registered grant tags; an in-flight read is
  // suppressed if reset lands in its data cycle.
  always_comb begin
    cop_rd_valid_o  = !reset_i && (tag_q == TAG_COP);
    host_rd_valid_o = !reset_i && (tag_q == TAG_HOST);
    cop_rd_data_o   = reset_i ? '0 : {even_rd_data_i, odd_rd_data_i};
    host_rd_data_o  = reset_i ? '0 : (host_bank_q ? odd_rd_data_i : even_rd_data_i);
    host_busy_o     = !reset_i && (rd_pending || wr_pending);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_pending     <= 1'b0;
      wr_pending     <= 1'b0;
      rd_addr_q      <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      starve_cnt     <= '0;
      tag_q          <= TAG_IDLE;
      host_bank_q    <= 1'b0;
      last_rd_addr_q <= '0;
    end else begin
      // A strobe seen while its register is still pending is dropped, even in
      // the cycle that pending request is granted.
      if (!rd_pending) begin
        if (host_rd_req_i) begin
          rd_pending <= 1'b1;
          rd_addr_q  <= host_rd_addr_i;
        end
      end else if (host_rd_gnt) begin
        rd_pending <= 1'b0;
      end

      if (!wr_pending) begin
        if (host_wr_req_i) begin
          wr_pending <= 1'b1;
          wr_addr_q  <= host_wr_addr_i;
          wr_data_q  <= host_wr_data_i;
        end
      end else if (host_wr_gnt) begin
        wr_pending <= 1'b0;
      end

      if (host_rd_gnt)
        starve_cnt <= '0;
      else if (cop_rd_gnt && rd_pending && starve_cnt != MAX_WAIT)
        starve_cnt <= starve_cnt + 1'b1;

      if (host_rd_gnt)
        tag_q <= TAG_HOST;
      else if (cop_rd_gnt)
        tag_q <= TAG_COP;
      else
        tag_q <= TAG_IDLE;

      if (host_rd_gnt)
        host_bank_q <= rd_addr_q[0];

      last_rd_addr_q <= rd_addr_nxt;
    end
  end

endmodule

// File: tb/tb_coppermem_arb.sv
// Directed bench for coppermem_arb with a behavioural read-first bank pair.
module tb_coppermem_arb;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        cop_rd_req_i;
  logic [9:0]  cop_rd_addr_i;
  logic        cop_rd_ack_o, cop_rd_valid_o;
  logic [31:0] cop_rd_data_o;
  logic        cop_wr_req_i;
  logic [10:0] cop_wr_addr_i;
  logic [15:0] cop_wr_data_i;
  logic        cop_wr_ack_o;
  logic        host_rd_req_i;
  logic [10:0] host_rd_addr_i;
  logic        host_rd_valid_o;
  logic [15:0] host_rd_data_o;
  logic        host_wr_req_i;
  logic [10:0] host_wr_addr_i;
  logic [15:0] host_wr_data_i;
  logic        host_busy_o;
  logic        even_rd_en_o, odd_rd_en_o;
  logic [9:0]  mem_rd_addr_o;
  logic [15:0] even_rd_data_i, odd_rd_data_i;
  logic        even_wr_en_o, odd_wr_en_o;
  logic [9:0]  mem_wr_addr_o;
  logic [15:0] mem_wr_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coppermem_arb #(.AWIDTH(10), .HOST_MAX_WAIT(4)) dut (
    .clk(clk), .reset_i(reset_i),
    .cop_rd_req_i(cop_rd_req_i), .cop_rd_addr_i(cop_rd_addr_i),
    .cop_rd_ack_o(cop_rd_ack_o), .cop_rd_valid_o(cop_rd_valid_o),
    .cop_rd_data_o(cop_rd_data_o),
    .cop_wr_req_i(cop_wr_req_i), .cop_wr_addr_i(cop_wr_addr_i),
    .cop_wr_data_i(cop_wr_data_i), .cop_wr_ack_o(cop_wr_ack_o),
    .host_rd_req_i(host_rd_req_i), .host_rd_addr_i(host_rd_addr_i),
    .host_rd_valid_o(host_rd_valid_o), .host_rd_data_o(host_rd_data_o),
    .host_wr_req_i(host_wr_req_i), .host_wr_addr_i(host_wr_addr_i),
    .host_wr_data_i(host_wr_data_i), .host_busy_o(host_busy_o),
    .even_rd_en_o(even_rd_en_o), .odd_rd_en_o(odd_rd_en_o),
    .mem_rd_addr_o(mem_rd_addr_o),
    .even_rd_data_i(even_rd_data_i), .odd_rd_data_i(odd_rd_data_i),
    .even_wr_en_o(even_wr_en_o), .odd_wr_en_o(odd_wr_en_o),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o)
  );

  // Bank pair: registered read-first; preload even[i]=i, odd[i]=i+0x100.
  logic [15:0] even_mem [1024];
  logic [15:0] odd_mem  [1024];
  logic        init_mem;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) begin
        even_mem[i] <= 16'(i);
        odd_mem[i]  <= 16'(i + 'h100);
      end
      even_rd_data_i <= '0;
      odd_rd_data_i  <= '0;
    end else begin
      if (even_rd_en_o) even_rd_data_i <= even_mem[mem_rd_addr_o];
      if (odd_rd_en_o)  odd_rd_data_i  <= odd_mem[mem_rd_addr_o];
      if (even_wr_en_o) even_mem[mem_wr_addr_o] <= mem_wr_data_o;
      if (odd_wr_en_o)  odd_mem[mem_wr_addr_o]  <= mem_wr_data_o;
    end
  end

  typedef struct {
    logic        rst, crd;
    logic [9:0]  cra;
    logic        cwr;
    logic [10:0] cwa;
    logic [15:0] cwd;
    logic        hrd;
    logic [10:0] hra;
    logic        hwr;
    logic [10:0] hwa;
    logic [15:0] hwd;
    logic [8:0]  flags;   // {cack,cvalid,hvalid,busy,ere,ore,ewe,owe,cwack}
    logic [9:0]  raddr;
    logic [31:0] cdata;
    logic [15:0] hdata;
    logic [9:0]  waddr;
    logic [15:0] wdata;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    cop_rd_req_i = 0; cop_rd_addr_i = '0;
    cop_wr_req_i = 0; cop_wr_addr_i = '0; cop_wr_data_i = '0;
    host_rd_req_i = 0; host_rd_addr_i = '0;
    host_wr_req_i = 0; host_wr_addr_i = '0; host_wr_data_i = '0;
  endtask

  task automatic begin_cycle();
    @(posedge clk); #1;
    reset_i = 0;
    clear_inputs();
  endtask

  function automatic logic [8:0] flags_now();
    return {cop_rd_ack_o, cop_rd_valid_o, host_rd_valid_o, host_busy_o,
            even_rd_en_o, odd_rd_en_o, even_wr_en_o, odd_wr_en_o, cop_wr_ack_o};
  endfunction

  int acks;
  int pulses;

  initial begin
    reset_i = 1; init_mem = 1;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    init_mem = 0;
    @(negedge clk);
    chk("reset_flags", 32'(flags_now()), 32'h0);
    chk("reset_raddr", 32'(mem_rd_addr_o), 32'h0);

    // Copper fetch stream: indices 0..7 back to back.
    for (int i = 0; i <= 8; i++) begin
      begin_cycle();
      cop_rd_req_i  = (i < 8);
      cop_rd_addr_i = 10'(i);
      @(negedge clk);
      chk($sformatf("stream_ack%0d", i), 32'(cop_rd_ack_o), 32'(i < 8));
      chk($sformatf("stream_valid%0d", i), 32'(cop_rd_valid_o), 32'(i > 0));
      if (i > 0)
        chk($sformatf("stream_data%0d", i - 1), cop_rd_data_o,
            {16'(i - 1), 16'(i - 1 + 'h100)});
    end

    // Starvation bound with a second host strobe dropped while pending.
    acks = 0; pulses = 0;
    for (int c = 0; c < 10; c++) begin
      begin_cycle();
      cop_rd_req_i  = 1;
      cop_rd_addr_i = 10'h10;
      if (c == 0) begin host_rd_req_i = 1; host_rd_addr_i = 11'h021; end
      if (c == 2) begin host_rd_req_i = 1; host_rd_addr_i = 11'h031; end
      @(negedge clk);
      chk($sformatf("starve_ack%0d", c), 32'(cop_rd_ack_o), 32'(c != 5));
      chk($sformatf("starve_busy%0d", c), 32'(host_busy_o), 32'(c >= 1 && c <= 5));
      if (host_busy_o && cop_rd_ack_o) acks++;
      if (host_rd_valid_o) begin
        pulses++;
        chk("starve_hdata", 32'(host_rd_data_o), 32'h0110);
      end
      if (c == 6) chk("starve_hvalid", 32'(host_rd_valid_o), 32'h1);
    end
    chk("starve_acks_while_pending", 32'(acks), 32'd4);
    chk("starve_host_pulses", 32'(pulses), 32'd1);

    // Reset in the data cycle of a host read, with a host write pending.
    begin_cycle(); host_rd_req_i = 1; host_rd_addr_i = 11'h040;
    begin_cycle(); host_wr_req_i = 1; host_wr_addr_i = 11'h041; host_wr_data_i = 16'h7777;
    @(negedge clk);
    chk("rst_mid_grant_ere", 32'(even_rd_en_o), 32'h1);
    begin_cycle(); reset_i = 1;
    @(negedge clk);
    chk("rst_mid_flags", 32'(flags_now()), 32'h0);
    begin_cycle();
    @(negedge clk);
    chk("rst_after_flags", 32'(flags_now()), 32'h0);
    begin_cycle(); host_rd_req_i = 1; host_rd_addr_i = 11'h041;
    @(negedge clk);
    chk("rst_new_strobe_flags", 32'(flags_now()), 32'h0);
    begin_cycle();
    @(negedge clk);
    chk("rst_new_grant_flags", 32'(flags_now()), 32'(9'b000101000));
    begin_cycle();
    @(negedge clk);
    chk("rst_new_valid", 32'(host_rd_valid_o), 32'h1);
    chk("rst_new_data", 32'(host_rd_data_o), 32'h0120);

    // Per-cycle vector table, starting from reset.
    //          rst crd cra cwr cwa cwd hrd hra hwr hwa hwd  flags  raddr cdata hdata waddr wdata
    vq.push_back('{1,0,0,0,0,0,0,0,0,0,0, 9'b000000000, 0, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b000000000, 0, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,5,16'h1234, 9'b000000000, 0, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b000100010, 0, 0, 0, 2, 16'h1234});
    vq.push_back('{0,0,0,0,0,0,1,5,0,0,0, 9'b000000000, 0, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b000101000, 2, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b001000000, 2, 0, 16'h1234, 0, 0});
    vq.push_back('{0,1,3,0,0,0,0,0,0,0,0, 9'b100011000, 3, 0, 0, 0, 0});
    vq.push_back('{0,1,4,0,0,0,0,0,0,0,0, 9'b110011000, 4, 32'h0003_0103, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b010000000, 4, 32'h0004_0104, 0, 0, 0});
    vq.push_back('{0,0,0,1,9,16'h5555,0,0,1,8,16'hBEEF, 9'b000000011, 4, 0, 0, 4, 16'h5555});
    vq.push_back('{0,0,0,1,9,16'h5556,0,0,0,0,0, 9'b000100100, 4, 0, 0, 4, 16'hBEEF});
    vq.push_back('{0,0,0,1,9,16'h5556,0,0,0,0,0, 9'b000000011, 4, 0, 0, 4, 16'h5556});
    vq.push_back('{0,0,0,0,0,0,1,8,0,0,0, 9'b000000000, 4, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,1,9,0,0,0, 9'b000110000, 4, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b001000000, 4, 0, 16'hBEEF, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b000000000, 4, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,1,9,0,0,0, 9'b000000000, 4, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b000101000, 4, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b001000000, 4, 0, 16'h5556, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,1,11'h7FF,16'hA5A5, 9'b000000000, 4, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b000100010, 4, 0, 0, 10'h3FF, 16'hA5A5});
    vq.push_back('{0,0,0,0,0,0,1,11'h7FF,0,0,0, 9'b000000000, 4, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b000101000, 10'h3FF, 0, 0, 0, 0});
    vq.push_back('{0,0,0,0,0,0,0,0,0,0,0, 9'b001000000, 10'h3FF, 0, 16'hA5A5, 0, 0});

    foreach (vq[k]) begin
      begin_cycle();
      reset_i = vq[k].rst;
      cop_rd_req_i = vq[k].crd;  cop_rd_addr_i = vq[k].cra;
      cop_wr_req_i = vq[k].cwr;  cop_wr_addr_i = vq[k].cwa;  cop_wr_data_i = vq[k].cwd;
      host_rd_req_i = vq[k].hrd; host_rd_addr_i = vq[k].hra;
      host_wr_req_i = vq[k].hwr; host_wr_addr_i = vq[k].hwa; host_wr_data_i = vq[k].hwd;
      @(negedge clk);
      chk($sformatf("vec%0d_flags", k), 32'(flags_now()), 32'(vq[k].flags));
      chk($sformatf("vec%0d_raddr", k), 32'(mem_rd_addr_o), 32'(vq[k].raddr));
      if (vq[k].flags[7])
        chk($sformatf("vec%0d_cdata", k), cop_rd_data_o, vq[k].cdata);
      if (vq[k].flags[6])
        chk($sformatf("vec%0d_hdata", k), 32'(host_rd_data_o), 32'(vq[k].hdata));
      if (vq[k].flags[2] || vq[k].flags[1]) begin
        chk($sformatf("vec%0d_waddr", k), 32'(mem_wr_addr_o), 32'(vq[k].waddr));
        chk($sformatf("vec%0d_wdata", k), 32'(mem_wr_data_o), 32'(vq[k].wdata));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
